// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Response owner encoding and MEM-stage ctrl bit positions.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_CPU  = 2'd1,
    RSP_DMA  = 2'd2
  } rsp_e;

  localparam int MEMREAD_BIT      = 4;
  localparam int MEMWRITE_BIT     = 3;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int WAIT_W           = 8;

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// 32-bit saturating event counter with enable and synchronous reset.
// Used for the optional arbiter statistics.
module dmem_arb_sat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA single-port data-memory arbiter with starvation guard.
// DMEM_ARB_STATS_EN adds stall and DMA-grant statistic counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_dma_grants
`endif
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic              cpu_acc;
  logic              cpu_gnt;
  logic              force_dma;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  rsp_e              rsp_q;
  rsp_e              rsp_d;
  logic              cpu_rvalid_q;
  logic              dma_rvalid_q;

  // Read and write together is treated as a bubble, not an access.
  assign cpu_acc   = cpu_rd ^ cpu_wr;
  assign force_dma = (wait_q == LIMIT);
  assign dma_gnt   = dma_req & (~cpu_acc | force_dma);
  assign cpu_gnt   = cpu_acc & ~dma_gnt;
  assign cpu_stall = cpu_acc & dma_gnt;

  always_comb begin
    mem_en    = dma_gnt | cpu_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      dma_gnt: begin
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      cpu_gnt: begin
        mem_we    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!dma_req || dma_gnt) begin
      wait_d = '0;
    end else if (wait_q < LIMIT) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    rsp_d = RSP_NONE;
    if (dma_gnt && !dma_we) begin
      rsp_d = RSP_DMA;
    end else if (cpu_gnt && cpu_rd) begin
      rsp_d = RSP_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q        <= RSP_NONE;
      wait_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      rsp_q        <= rsp_d;
      wait_q       <= wait_d;
      cpu_rvalid_q <= (rsp_d == RSP_CPU);
      dma_rvalid_q <= (rsp_d == RSP_DMA);
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign cpu_rdata  = (rsp_q == RSP_CPU) ? mem_rdata : '0;
  assign dma_rdata  = (rsp_q == RSP_DMA) ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_sat_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (cpu_stall),
    .cnt_o (stat_stall_cycles)
  );

  dmem_arb_sat_cnt u_gnt_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (dma_gnt),
    .cnt_o (stat_dma_grants)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus
// randomized traffic against a behavioural arbitration model.
module tb_dmem_arbiter;

  localparam int LIM = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_stall_cycles, stat_dma_grants;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic        init_mem;
  logic [31:0] mem_arr [256];
  logic [31:0] sh [256];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_dma_grants   (stat_dma_grants)
`endif
  );

  function automatic logic [31:0] base(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // Synchronous memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= base(i);
    end else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
      else mem_rdata <= mem_arr[mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; init_mem = 1; idle();
    tick(); tick();
    init_mem = 0;
    #3;
    n_tests++;
    if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rvalid: got %b want 00", {cpu_rvalid, dma_rvalid});
    end
    n_tests++;
    if ({cpu_rdata, dma_rdata} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dma_rdata);
    end
    n_tests++;
    if ({mem_en, cpu_stall, dma_gnt, mem_we} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_comb: got %b want 0000",
               {mem_en, cpu_stall, dma_gnt, mem_we});
    end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h1234_5678;
    #3;
    n_tests++;
    if ({dma_gnt, mem_en, mem_we, cpu_stall} !== 4'b1110 ||
        mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL dma_write: got gnt/en/we/stall=%b addr=%h wd=%h want 1110 200 12345678",
               {dma_gnt, mem_en, mem_we, cpu_stall}, mem_addr, mem_wdata);
    end
    sh[8'h80] = 32'h1234_5678;
    tick();
    idle();
    #3;
    n_tests++;
    if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL dma_write_norsp: got %b want 00", {cpu_rvalid, dma_rvalid});
    end
    tick();
  endtask

  task automatic test_cpu_load();
    dma_req = 1; dma_we = 1; dma_addr = 32'h100; dma_wdata = 32'hDEAD_BEEF;
    sh[8'h40] = 32'hDEAD_BEEF;
    tick();
    idle();
    cpu_rd = 1; cpu_addr = 32'h100;
    #3;
    n_tests++;
    if ({mem_en, mem_we, cpu_stall} !== 3'b100 || mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL cpu_load_issue: got en/we/stall=%b addr=%h want 100 100",
               {mem_en, mem_we, cpu_stall}, mem_addr);
    end
    tick();
    idle();
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    #3;
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF || dma_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_load_rsp: got v=%b d=%h dv=%b want 1 deadbeef 0",
               cpu_rvalid, cpu_rdata, dma_rvalid);
    end
    tick();
    idle();
    #3;
    n_tests++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== sh[8'h80] || cpu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL dma_read_rsp: got v=%b d=%h cd=%h want 1 %h 0",
               dma_rvalid, dma_rdata, cpu_rdata, sh[8'h80]);
    end
    tick();
  endtask

  task automatic test_both_high();
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h100;
    #3;
    n_tests++;
    if ({mem_en, cpu_stall, dma_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL both_high: got en/stall/gnt=%b want 000",
               {mem_en, cpu_stall, dma_gnt});
    end
    tick();
    dma_req = 1; dma_we = 1; dma_addr = 32'h3F0; dma_wdata = 32'h0BAD_F00D;
    sh[8'hFC] = 32'h0BAD_F00D;
    #3;
    n_tests++;
    if ({dma_gnt, cpu_stall, cpu_rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL both_high_dma: got gnt/stall/rv=%b want 100",
               {dma_gnt, cpu_stall, cpu_rvalid});
    end
    tick();
    idle();
    tick();
  endtask

  // CPU loads every cycle; returns the request cycle that got the grant.
  task automatic starve_run(output int gc, output int bad_stall);
    gc = 0;
    bad_stall = 0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200; dma_wdata = 0;
    for (int c = 1; c <= LIM + 4 && gc == 0; c++) begin
      cpu_rd = 1; cpu_wr = 0;
      cpu_addr = 32'($urandom_range(0, 255)) << 2;
      #3;
      if (cpu_stall !== dma_gnt) bad_stall++;
      if (dma_gnt === 1'b1) gc = c;
      tick();
    end
  endtask

  task automatic test_starve();
    int gc, bs;
    starve_run(gc, bs);
    n_tests++;
    if (gc != LIM + 1) begin
      n_fail++;
      $display("FAIL starve_gnt_cycle: got %0d want %0d", gc, LIM + 1);
    end
    n_tests++;
    if (bs != 0) begin
      n_fail++;
      $display("FAIL starve_stall: got %0d mismatched cycles want 0", bs);
    end
    idle();
    #3;
    n_tests++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== sh[8'h80] || cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_rsp: got dv=%b d=%h cv=%b want 1 %h 0",
               dma_rvalid, dma_rdata, cpu_rvalid, sh[8'h80]);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    int gc, bs;
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    cpu_rd = 1; cpu_addr = 32'h100;
    for (int i = 0; i < 4; i++) tick();
    reset = 1;
    tick();
    reset = 0;
    idle();
    #3;
    n_tests++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_read: got v=%b d=%h want 0 0", cpu_rvalid, cpu_rdata);
    end
    tick();
    starve_run(gc, bs);
    n_tests++;
    if (gc != LIM + 1) begin
      n_fail++;
      $display("FAIL reset_wait_clear: got gnt cycle %0d want %0d", gc, LIM + 1);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    int owner;
    owner = 0;
    exp_d = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i[0]) begin
        dma_req = 1; dma_addr = 32'($urandom_range(0, 255)) << 2;
      end else begin
        cpu_rd = 1; cpu_addr = 32'($urandom_range(0, 255)) << 2;
      end
      #3;
      if (i > 0) begin
        n_tests++;
        if (owner == 1 && (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_d ||
                           dma_rvalid !== 1'b0)) begin
          n_fail++;
          $display("FAIL b2b_cpu: got v=%b d=%h want 1 %h", cpu_rvalid, cpu_rdata, exp_d);
        end
        if (owner == 2 && (dma_rvalid !== 1'b1 || dma_rdata !== exp_d ||
                           cpu_rvalid !== 1'b0)) begin
          n_fail++;
          $display("FAIL b2b_dma: got v=%b d=%h want 1 %h", dma_rvalid, dma_rdata, exp_d);
        end
      end
      owner = i[0] ? 2 : 1;
      exp_d = i[0] ? sh[dma_addr[9:2]] : sh[cpu_addr[9:2]];
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    int wcnt, owner, pend, k;
    logic [31:0] exp_d;
    logic acc, eg, ec;
    wcnt = 0; owner = 0; pend = 0; exp_d = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      k = $urandom_range(0, 7);
      cpu_rd = (k inside {1, 2, 3, 7});
      cpu_wr = (k inside {4, 5, 7});
      cpu_addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2);
      cpu_wdata = $urandom;
      if (pend != 0) begin
        if ($urandom_range(0, 15) == 0) dma_req = 0;
      end else begin
        dma_req = ($urandom_range(0, 2) == 0);
        dma_we = $urandom_range(0, 1);
        dma_addr = 32'($urandom_range(0, 255)) << 2;
        dma_wdata = $urandom;
      end
      #3;
      acc = cpu_rd ^ cpu_wr;
      eg = dma_req && (!acc || wcnt == LIM);
      ec = acc && !eg;
      n_tests++;
      if (dma_gnt !== eg || cpu_stall !== (acc && eg) || mem_en !== (eg || ec)) begin
        n_fail++;
        $display("FAIL rnd_gnt cyc%0d: got gnt/stall/en=%b%b%b want %b%b%b",
                 cyc, dma_gnt, cpu_stall, mem_en, eg, acc && eg, eg || ec);
      end
      n_tests++;
      if (eg && (mem_we !== dma_we || mem_addr !== dma_addr || mem_wdata !== dma_wdata) ||
          ec && (mem_we !== cpu_wr || mem_addr !== cpu_addr || mem_wdata !== cpu_wdata) ||
          !eg && !ec && {mem_we, mem_addr, mem_wdata} !== 65'd0) begin
        n_fail++;
        $display("FAIL rnd_mux cyc%0d: got we=%b a=%h d=%h", cyc, mem_we, mem_addr, mem_wdata);
      end
      n_tests++;
      if (cpu_rvalid !== (owner == 1) || dma_rvalid !== (owner == 2) ||
          cpu_rdata !== (owner == 1 ? exp_d : 32'd0) ||
          dma_rdata !== (owner == 2 ? exp_d : 32'd0)) begin
        n_fail++;
        $display("FAIL rnd_rsp cyc%0d: got cv=%b cd=%h dv=%b dd=%h want owner %0d data %h",
                 cyc, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata, owner, exp_d);
      end
      owner = 0;
      if (eg) begin
        if (dma_we) sh[dma_addr[9:2]] = dma_wdata;
        else begin owner = 2; exp_d = sh[dma_addr[9:2]]; end
      end else if (ec) begin
        if (cpu_wr) sh[cpu_addr[9:2]] = cpu_wdata;
        else begin owner = 1; exp_d = sh[cpu_addr[9:2]]; end
      end
      wcnt = (!dma_req || eg) ? 0 : (wcnt < LIM ? wcnt + 1 : wcnt);
      pend = (dma_req && !eg) ? 1 : 0;
      tick();
    end
    idle();
    tick();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    int gc, bs;
    reset = 1;
    tick();
    reset = 0;
    for (int r = 0; r < 3; r++) begin
      starve_run(gc, bs);
      idle();
      tick();
    end
    #3;
    n_tests++;
    if (stat_dma_grants !== 32'd3 || stat_stall_cycles !== 32'd3) begin
      n_fail++;
      $display("FAIL stats: got grants=%0d stalls=%0d want 3 3",
               stat_dma_grants, stat_stall_cycles);
    end
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) sh[i] = base(i);
    test_reset();
    test_dma_write();
    test_cpu_load();
    test_both_high();
    test_starve();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage (CPU port) and a DMA/loader port. CPU accesses have priority; DMA is served on idle cycles or forcibly after a bounded wait, with the CPU stalled for that cycle. Read data returns one cycle after grant, tagged to the owner recorded by a small response FSM. Sits between the MEM stage address/write-data outputs and the synchronous data memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 8, consecutive denied DMA request cycles before a forced DMA grant; legal range 1..255
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cpu_rd`  in  1  MEM-stage memread (ctrl bit 4)
- `cpu_wr`  in  1  MEM-stage memwrite (ctrl bit 3)
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_stall`  out  1  CPU access requested but not granted this cycle
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  DATA_W  CPU read data
- `dma_req`  in  1  DMA access request, held until `dma_gnt`
- `dma_we`  in  1  DMA write (1) / read (0)
- `dma_addr`  in  ADDR_W  DMA address
- `dma_wdata`  in  DATA_W  DMA write data
- `dma_gnt`  out  1  DMA access issued this cycle
- `dma_rvalid`  out  1  DMA read data valid
- `dma_rdata`  out  DATA_W  DMA read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid cycle after `mem_en` with `mem_we`=0

## Operation
- CPU access valid iff `cpu_rd` XOR `cpu_wr`; both high or both low = no access, never stalls.
- Grant (combinational, per cycle): DMA if `dma_req` and (no CPU access or `wait_cnt` == `STARVE_LIMIT`); else CPU if CPU access; else none.
- `wait_cnt` (8 bit): increments when `dma_req` high and not granted; clears on `dma_gnt` or `dma_req` low; never exceeds `STARVE_LIMIT`.
- `cpu_stall` = CPU access valid and DMA granted.
- Memory mux: granted requester's addr/wdata/we drive `mem_*`; `mem_en`=1 only with a grant; with no grant `mem_addr`/`mem_wdata`/`mem_we` = 0.
- Response FSM, states RSP_NONE, RSP_CPU, RSP_DMA; next state = owner of a granted read this cycle, else RSP_NONE. Writes never create a response.
- RSP_CPU: `cpu_rvalid`=1, `cpu_rdata`=`mem_rdata`. RSP_DMA: `dma_rvalid`=1, `dma_rdata`=`mem_rdata`. Unselected rdata outputs = 0.

## Timing
- Reset: state RSP_NONE, `wait_cnt`=0; all registered outputs 0 (`cpu_rvalid`, `dma_rvalid`, rdata outputs); combinational outputs follow inputs (0 when no requests).
- Grant/stall/`mem_*`: same cycle as request (0 latency). Read response: 1 cycle after grant.
- Back-to-back reads by alternating owners supported every cycle; no bubbles.
- Reset asserted mid-read: pending response dropped, no rvalid next cycle.
- `dma_req` dropped before grant: no access, `wait_cnt` clears.
- Forced grant: with CPU busy every cycle, DMA granted in the cycle after `STARVE_LIMIT` denied cycles (cycle `STARVE_LIMIT`+1 of request).

## Configuration
- `DMEM_ARB_STATS_EN` defined: adds outputs `stat_stall_cycles` (32) and `stat_dma_grants` (32); each increments by 1 on `cpu_stall` / `dma_gnt` respectively, saturates at 0xFFFFFFFF, clears on `reset`.
- Undefined: ports and counters absent; arbitration behaviour identical.

## Structure
- Package `dmem_arb_pkg`: response-state enum (RSP_NONE/RSP_CPU/RSP_DMA), ctrl bit indices (MEMREAD_BIT=4, MEMWRITE_BIT=3), default `STARVE_LIMIT`.
- Sub-module `dmem_arb_sat_cnt` (32-bit saturating counter, enable + sync reset), instantiated twice only under `DMEM_ARB_STATS_EN`.

## Test plan
- CPU load 0x100, no DMA, mem returns 0xDEADBEEF -> `mem_en`=1, `mem_we`=0, `cpu_stall`=0; next cycle `cpu_rvalid`=1, `cpu_rdata`=0xDEADBEEF, `dma_rvalid`=0.
- DMA write 0x200/0x12345678 with CPU idle -> `dma_gnt`=1 same cycle, `mem_we`=1, `mem_addr`=0x200; no rvalid next cycle.
- CPU loads every cycle, DMA read held, STARVE_LIMIT=8 -> `dma_gnt` on request cycle 9, `cpu_stall`=1 exactly that cycle, `dma_rvalid` next cycle.
- `cpu_rd`=`cpu_wr`=1 with `dma_req`=0 -> `mem_en`=0, `cpu_stall`=0.
- CPU read granted, `reset` asserted next edge -> `cpu_rvalid`=0 after reset, `wait_cnt`=0.
- With `DMEM_ARB_STATS_EN`: 3 forced grants -> `stat_dma_grants`=3, `stat_stall_cycles`=3.
